// File: rtl/axis_packet_proc.sv
// axis_packet_proc: buffers one AXI-Stream packet, XOR-checksums it, then echoes it
// in order, reversed, or in order with the checksum word appended.
module axis_packet_proc #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_DEPTH            = 8,
    parameter int C_MODE             = 0
) (
    input  logic                            AXIS_ACLK,
    input  logic                            AXIS_ARESETN,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                            S_AXIS_TLAST,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                            M_AXIS_TLAST,
    output logic [3:0]                      led,
    output logic                            truncated,
    output logic [15:0]                     pkt_count
);
    localparam int AW = $clog2(C_DEPTH);
    localparam int W  = C_AXIS_TDATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RECV, PROC, SEND} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  buffer [C_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   len, idx, last_idx, sel;
    logic [W-1:0]  checksum, word, proc_sum;
    logic          s_acc, m_acc, recv_done, proc_done, send_done;
    logic          unused_tstrb;

    assign unused_tstrb = ^S_AXIS_TSTRB;
    assign s_acc        = state == RECV && S_AXIS_TVALID;
    assign recv_done    = s_acc && (S_AXIS_TLAST || wr_ptr == AW'(C_DEPTH - 1));
    assign proc_done    = state == PROC && idx == len - 1'b1;
    assign proc_sum     = checksum ^ buffer[idx[AW-1:0]];
    assign last_idx     = C_MODE == 2 ? len : len - 1'b1;
    assign m_acc        = state == SEND && M_AXIS_TREADY;
    assign send_done    = m_acc && idx == last_idx;
    // mode 1 reads backwards from the last stored word
    assign sel          = C_MODE == 1 ? last_idx - idx : idx;
    assign word         = (C_MODE == 2 && idx == len) ? checksum : buffer[sel[AW-1:0]];
    assign M_AXIS_TSTRB = '1;

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = S_AXIS_TVALID ? RECV : IDLE;
            RECV:    state_nxt = recv_done ? PROC : RECV;
            PROC:    state_nxt = proc_done ? SEND : PROC;
            default: state_nxt = send_done ? IDLE : SEND;
        endcase
    end

    always_comb begin
        S_AXIS_TREADY = state == RECV;
        M_AXIS_TVALID = state == SEND;
        M_AXIS_TLAST  = state == SEND && idx == last_idx;
        M_AXIS_TDATA  = state == SEND ? word : '0;
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (s_acc)
            buffer[wr_ptr] <= S_AXIS_TDATA;
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            wr_ptr    <= '0;
            len       <= '0;
            idx       <= '0;
            checksum  <= '0;
            led       <= '0;
            truncated <= 1'b0;
            pkt_count <= '0;
        end else begin
            if (s_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (recv_done) begin
                len       <= {1'b0, wr_ptr} + 1'b1;
                truncated <= !S_AXIS_TLAST && wr_ptr == AW'(C_DEPTH - 1);
                checksum  <= '0;
                idx       <= '0;
            end
            if (state == PROC) begin
                checksum <= proc_sum;
                idx      <= proc_done ? '0 : idx + 1'b1;
            end
            if (proc_done)
                led <= proc_sum != '0 ? 4'b0011 : 4'b1100;
            if (m_acc)
                idx <= idx + 1'b1;
            if (send_done) begin
                pkt_count <= pkt_count + 1'b1;
                wr_ptr    <= '0;
                idx       <= '0;
            end
        end
    end
endmodule

// File: tb/tb_axis_packet_proc.sv
// tb_axis_packet_proc: scoreboard bench driving one instance per output mode.
module tb_axis_packet_proc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  s_tvalid = '0, s_tlast = '0, s_tready, m_tvalid, m_tlast, trunc;
    logic [2:0]  m_tready = '0;
    logic [31:0] s_tdata [3];
    logic [31:0] m_tdata [3];
    logic [3:0]  m_tstrb [3];
    logic [3:0]  led [3];
    logic [15:0] cnt [3];
    logic [15:0] exp_cnt [3];
    logic [31:0] pkt [$];
    logic [32:0] exp_q [$];
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        axis_packet_proc #(.C_MODE(g)) dut (
            .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
            .S_AXIS_TVALID(s_tvalid[g]), .S_AXIS_TREADY(s_tready[g]),
            .S_AXIS_TDATA(s_tdata[g]), .S_AXIS_TSTRB(4'hF), .S_AXIS_TLAST(s_tlast[g]),
            .M_AXIS_TVALID(m_tvalid[g]), .M_AXIS_TREADY(m_tready[g]),
            .M_AXIS_TDATA(m_tdata[g]), .M_AXIS_TSTRB(m_tstrb[g]), .M_AXIS_TLAST(m_tlast[g]),
            .led(led[g]), .truncated(trunc[g]), .pkt_count(cnt[g])
        );
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic void expect_pkt(input int m, input int s, input int n);
        logic [31:0] x;
        logic        l;
        x = '0;
        for (int k = 0; k < n; k++) begin
            x ^= pkt[s + k];
            l = (m != 2) && (k == n - 1);
            exp_q.push_back({l, m == 1 ? pkt[s + n - 1 - k] : pkt[s + k]});
        end
        if (m == 2)
            exp_q.push_back({1'b1, x});
    endfunction

    task automatic drive(input int m, input int n, input bit last_on_end);
        for (int i = 0; i < n; i++) begin
            int cyc;
            cyc = 0;
            s_tvalid[m] = 1'b1;
            s_tdata[m]  = pkt[i];
            s_tlast[m]  = last_on_end && i == n - 1;
            while (!s_tready[m] && cyc < 2000) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 2000) begin
                total++;
                $display("FAIL drive_timeout: got no TREADY for word %0d required TREADY=1", i);
            end
            @(negedge clk);
        end
        s_tvalid[m] = 1'b0;
        s_tlast[m]  = 1'b0;
    endtask

    task automatic collect(input int m, input int nb, input bit rnd);
        int          got, cyc;
        logic        held_v;
        logic [31:0] held;
        logic [32:0] e;
        got = 0; cyc = 0; held_v = 1'b0; held = '0;
        while (got < nb && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (held_v) begin
                total++;
                if (m_tdata[m] !== held || m_tvalid[m] !== 1'b1 || s_tready[m] !== 1'b0)
                    $display("FAIL stall_hold m%0d: got data=%h valid=%b sready=%b required data=%h valid=1 sready=0",
                             m, m_tdata[m], m_tvalid[m], s_tready[m], held);
                else
                    passed++;
            end
            m_tready[m] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held_v = 1'b0;
            if (m_tvalid[m] && !m_tready[m]) begin
                held_v = 1'b1;
                held   = m_tdata[m];
            end else if (m_tvalid[m]) begin
                e = exp_q.size() != 0 ? exp_q.pop_front() : 33'h1_DEADBEEF;
                total++;
                if ({m_tlast[m], m_tdata[m]} !== e)
                    $display("FAIL beat m%0d#%0d: got last=%b data=%h required last=%b data=%h",
                             m, got, m_tlast[m], m_tdata[m], e[32], e[31:0]);
                else
                    passed++;
                got++;
            end
        end
        if (got < nb) begin
            total++;
            $display("FAIL collect_timeout m%0d: got %0d beats required %0d", m, got, nb);
        end
        @(negedge clk);
        m_tready[m] = 1'b0;
        exp_cnt[m]++;
        total++;
        if (m_tvalid[m] !== 1'b0 || cnt[m] !== exp_cnt[m])
            $display("FAIL pkt_end m%0d: got valid=%b count=%0d required valid=0 count=%0d",
                     m, m_tvalid[m], cnt[m], exp_cnt[m]);
        else
            passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            total++;
            if ({s_tready[m], m_tvalid[m], m_tlast[m], trunc[m]} !== 4'b0 || m_tdata[m] !== '0 ||
                led[m] !== 4'b0 || cnt[m] !== 16'd0 || m_tstrb[m] !== 4'hF)
                $display("FAIL reset m%0d: got rdy=%b vld=%b last=%b tr=%b data=%h led=%b cnt=%0d strb=%h required zeros strb=f",
                         m, s_tready[m], m_tvalid[m], m_tlast[m], trunc[m], m_tdata[m], led[m], cnt[m], m_tstrb[m]);
            else
                passed++;
            exp_cnt[m] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        pkt = '{32'h1, 32'h2, 32'h4, 32'h8};
        expect_pkt(0, 0, 4);
        fork drive(0, 4, 1); collect(0, 4, 0); join
        total++;
        if (led[0] !== 4'b0011 || trunc[0] !== 1'b0)
            $display("FAIL basic_led: got led=%b tr=%b required led=0011 tr=0", led[0], trunc[0]);
        else
            passed++;
    endtask

    task automatic test_modes();
        pkt = '{32'hA, 32'hB, 32'hC};
        expect_pkt(1, 0, 3);
        fork drive(1, 3, 1); collect(1, 3, 0); join
        expect_pkt(2, 0, 3);
        fork drive(2, 3, 1); collect(2, 4, 0); join
        total++;
        if (led[2] !== 4'b0011)
            $display("FAIL mode2_led: got %b required 0011", led[2]);
        else
            passed++;
    endtask

    task automatic test_zero_checksum();
        pkt = '{32'h5, 32'h5};
        expect_pkt(0, 0, 2);
        fork drive(0, 2, 1); collect(0, 2, 0); join
        total++;
        if (led[0] !== 4'b1100)
            $display("FAIL zero_led: got %b required 1100", led[0]);
        else
            passed++;
    endtask

    task automatic test_truncate();
        pkt = {};
        for (int i = 1; i <= 10; i++)
            pkt.push_back(32'(i));
        expect_pkt(0, 0, 8);
        expect_pkt(0, 8, 2);
        fork
            drive(0, 10, 1);
            begin
                collect(0, 8, 0);
                total++;
                if (trunc[0] !== 1'b1)
                    $display("FAIL truncated_set: got %b required 1", trunc[0]);
                else
                    passed++;
                collect(0, 2, 0);
                total++;
                if (trunc[0] !== 1'b0)
                    $display("FAIL truncated_clr: got %b required 0", trunc[0]);
                else
                    passed++;
            end
        join
    endtask

    task automatic test_stall();
        for (int m = 0; m < 3; m++) begin
            int n;
            n = $urandom_range(1, 8);
            pkt = {};
            for (int i = 0; i < n; i++)
                pkt.push_back($urandom);
            expect_pkt(m, 0, n);
            fork
                drive(m, n, 1);
                begin
                    repeat (n + 20) @(negedge clk);
                    total++;
                    if (m_tvalid[m] !== 1'b1 || s_tready[m] !== 1'b0 || m_tdata[m] !== (m == 1 ? pkt[n-1] : pkt[0]))
                        $display("FAIL long_stall m%0d: got valid=%b sready=%b data=%h required 1 0 first word",
                                 m, m_tvalid[m], s_tready[m], m_tdata[m]);
                    else
                        passed++;
                    collect(m, m == 2 ? n + 1 : n, 1);
                end
            join
        end
    endtask

    task automatic test_reset_mid_send();
        int cyc;
        pkt = '{32'h11, 32'h22, 32'h33, 32'h44};
        drive(0, 4, 1);
        cyc = 0;
        while (!m_tvalid[0] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        m_tready[0] = 1'b1;
        @(negedge clk);
        m_tready[0] = 1'b0;
        total++;
        if (m_tdata[0] !== 32'h22 || m_tvalid[0] !== 1'b1)
            $display("FAIL mid_send_beat2: got valid=%b data=%h required valid=1 data=22", m_tvalid[0], m_tdata[0]);
        else
            passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({m_tvalid[0], m_tlast[0], s_tready[0], trunc[0]} !== 4'b0 || m_tdata[0] !== '0 ||
            led[0] !== 4'b0 || cnt[0] !== 16'd0)
            $display("FAIL async_reset: got vld=%b last=%b rdy=%b tr=%b data=%h led=%b cnt=%0d required zeros",
                     m_tvalid[0], m_tlast[0], s_tready[0], trunc[0], m_tdata[0], led[0], cnt[0]);
        else
            passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int m = 0; m < 3; m++)
            exp_cnt[m] = '0;
        exp_q.delete();
        @(negedge clk);
        pkt = '{32'h100, 32'h200};
        expect_pkt(0, 0, 2);
        fork drive(0, 2, 1); collect(0, 2, 0); join
    endtask

    task automatic test_wrap_and_single();
        force g_dut[0].dut.pkt_count = 16'hFFFF;
        @(negedge clk);
        release g_dut[0].dut.pkt_count;
        exp_cnt[0] = 16'hFFFF;
        pkt = '{32'h77};
        expect_pkt(0, 0, 1);
        fork drive(0, 1, 1); collect(0, 1, 0); join
        pkt = '{32'h9};
        expect_pkt(2, 0, 1);
        fork drive(2, 1, 1); collect(2, 2, 0); join
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_zero_checksum();
        test_truncate();
        test_stall();
        test_reset_mid_send();
        test_wrap_and_single();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/axis_packet_proc.md
AXIS_PACKET_PROC -- requirements
Module: axis_packet_proc

Interface
REQ-001 Parameter C_AXIS_TDATA_WIDTH, default 32: S and M TDATA width; multiple of 8, >= 8.
REQ-002 Parameter C_DEPTH, default 8: maximum packet length in words; power of 2, >= 2.
REQ-003 Parameter C_MODE, default 0: output mode. 0 = echo in order; 1 = echo reversed; 2 = echo in order, then append one XOR-checksum word.
REQ-004 AXIS_ACLK  in  1  sole clock; all logic on its rising edge.
REQ-005 AXIS_ARESETN  in  1  reset; asynchronous assert, active-low, synchronous deassert by the integrator.
REQ-006 S_AXIS_TVALID  in  1  sink data valid.
REQ-007 S_AXIS_TREADY  out  1  sink ready.
REQ-008 S_AXIS_TDATA  in  C_AXIS_TDATA_WIDTH  sink payload.
REQ-009 S_AXIS_TSTRB  in  C_AXIS_TDATA_WIDTH/8  ignored.
REQ-010 S_AXIS_TLAST  in  1  end of input packet.
REQ-011 M_AXIS_TVALID  out  1  source data valid.
REQ-012 M_AXIS_TREADY  in  1  source ready.
REQ-013 M_AXIS_TDATA  out  C_AXIS_TDATA_WIDTH  source payload.
REQ-014 M_AXIS_TSTRB  out  C_AXIS_TDATA_WIDTH/8  constant all ones.
REQ-015 M_AXIS_TLAST  out  1  last output beat.
REQ-016 led  out  4  checksum status.
REQ-017 truncated  out  1  last packet hit C_DEPTH without TLAST.
REQ-018 pkt_count  out  16  packets fully sent, wraps 0xFFFF -> 0.

Function
REQ-019 FSM states IDLE, RECV, PROC, SEND; IDLE->RECV when S_AXIS_TVALID=1; S_AXIS_TREADY=0 in IDLE.
REQ-020 RECV: S_AXIS_TREADY=1; each beat with TVALID&&TREADY stored at buffer[wr_ptr], wr_ptr increments.
REQ-021 RECV exits to PROC on the accepted beat with TLAST=1 or wr_ptr=C_DEPTH-1; latch len=wr_ptr+1 (range 1..C_DEPTH) and truncated=(TLAST==0 && wr_ptr==C_DEPTH-1); TREADY deasserts the next cycle.
REQ-022 Input beats beyond C_DEPTH are not accepted by this packet; they start the next packet after SEND completes.
REQ-023 PROC: one buffer word per cycle, checksum = XOR of buffer[0..len-1]; duration exactly len cycles, then SEND.
REQ-024 On PROC exit: led=4'b0011 if checksum!=0, else 4'b1100; led holds until next PROC exit.
REQ-025 SEND: M_AXIS_TVALID=1 every cycle; output length = len, or len+1 in mode 2.
REQ-026 Beat k (0-based) data: mode 0/2 buffer[k]; mode 1 buffer[len-1-k]; mode 2 beat len = checksum.
REQ-027 M_AXIS_TLAST=1 only on the final output beat; TDATA/TLAST stable while TVALID=1 and TREADY=0.
REQ-028 M_AXIS_TDATA/TVALID/TLAST derive from registered state only; no combinational path from any input.
REQ-029 Final-beat handshake: pkt_count increments, FSM -> IDLE, M_AXIS_TVALID=0 next cycle; wr_ptr and read index cleared.
REQ-030 M_AXIS_TREADY held 0 stalls SEND indefinitely; no data loss, no S-side acceptance meanwhile.
REQ-031 len=1: one output beat with TLAST=1 (mode 2: two beats, data word then checksum with TLAST).

Reset
REQ-032 AXIS_ARESETN=0 forces immediately, independent of clock: state IDLE, S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, led=0, truncated=0, pkt_count=0, pointers/len/checksum 0.
REQ-033 Reset in any state abandons the packet in flight; buffer contents are not reset and not reused.

Verification
REQ-034 Mode 0, 4 words 0x1,0x2,0x4,0x8 TLAST on 4th, TREADY=1 -> out 0x1,0x2,0x4,0x8, TLAST on 4th, led=0011, pkt_count=1.
REQ-035 Mode 1, 3 words 0xA,0xB,0xC -> out 0xC,0xB,0xA; mode 2 same input -> 0xA,0xB,0xC,0xD, TLAST on 0xD.
REQ-036 Mode 0, words 0x5,0x5 -> checksum 0, led=1100; 10 words no TLAST, C_DEPTH=8 -> 8 out, truncated=1, words 9-10 form next packet.
REQ-037 M_AXIS_TREADY random 50% -> output sequence exact, TDATA stable across every stalled cycle.
REQ-038 Reset asserted mid-SEND (beat 2 of 4) -> outputs at reset values before next clock edge; new 2-word packet afterwards sent correctly, pkt_count=1.
REQ-039 pkt_count preloaded by 65535 packets -> next completion reads 0.
